// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR conversion controller.
// Optional feature macro: SAR_AVG_EN (4x per-channel averaging).
package sar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SAMPLE,
        ST_CONVERT,
        ST_DONE
    } sar_state_e;

    localparam int N_CH_DEF       = 4;
    localparam int RES_DEF        = 8;
    localparam int SAMPLE_CYC_DEF = 4;
    localparam int SETTLE_DEF     = 3;

    // Cycles from the accepted start edge to the result_valid pulse.
    function automatic int sar_latency(input int sample_cyc, input int res, input int settle);
        return 1 + sample_cyc + res * (settle + 1);
    endfunction

endpackage

// File: rtl/sar_rr_pick.sv
// Round-robin channel picker: returns the first pending channel found
// after the last-converted channel, wrapping around.
module sar_rr_pick
    import sar_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    localparam int CW  = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] pending_i,
    input  logic [CW-1:0]   last_i,
    output logic [CW-1:0]   idx_o,
    output logic            found_o
);

    logic [CW-1:0] cand;

    // Scan from farthest to nearest so the nearest pending channel wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int k = N_CH; k >= 1; k--) begin
            cand = CW'((int'(last_i) + k) % N_CH);
            if (pending_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sar_scan_ctrl.sv
// SAR conversion sequencer and round-robin channel scheduler for the
// shared track/hold, capacitive DAC and comparator.
// Optional feature macro: SAR_AVG_EN (each channel converted 4 times,
// result is the truncated mean).
module sar_scan_ctrl
    import sar_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int RES        = RES_DEF,
    parameter int SAMPLE_CYC = SAMPLE_CYC_DEF,
    parameter int SETTLE     = SETTLE_DEF,
    localparam int CW        = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            cont,
    input  logic            abort,
    input  logic [N_CH-1:0] ch_mask,
    input  logic            cmp_in,
    output logic            sample,
    output logic [CW-1:0]   ch_sel,
    output logic [RES-1:0]  dac_code,
    output logic            busy,
    output logic            result_valid,
    output logic [RES-1:0]  result,
    output logic [CW-1:0]   result_ch
);

    localparam int BW    = $clog2(RES);
    localparam int CNT_W = 8;

    sar_state_e      state_q, state_d;
    logic [N_CH-1:0] mask_q, pending_q, pick_oh;
    logic [CW-1:0]   ch_q, last_q, pick_idx;
    logic            pick_found;
    logic [CNT_W-1:0] cnt_q;
    logic [BW-1:0]   bit_q;
    logic [RES-1:0]  code_q, trial_oh, new_code;
    logic [RES-1:0]  result_q;
    logic [CW-1:0]   result_ch_q;
    logic            sync1_q, sync2_q;
    logic            sample_end, bit_end, conv_end, last_pass;

`ifdef SAR_AVG_EN
    logic [1:0]      avg_q;
    logic [RES+1:0]  acc_q, acc_n;
    assign acc_n     = acc_q + {2'b00, new_code};
    assign last_pass = (avg_q == 2'd3);
`else
    assign last_pass = 1'b1;
`endif

    sar_rr_pick #(.N_CH(N_CH)) u_pick (
        .pending_i (pending_q),
        .last_i    (last_q),
        .idx_o     (pick_idx),
        .found_o   (pick_found)
    );

    // Decode helpers: one-hot of picked channel and of the trial bit, kept code.
    always_comb begin
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
        trial_oh          = '0;
        trial_oh[bit_q]   = 1'b1;
        new_code          = code_q | (sync2_q ? trial_oh : '0);
    end

    assign sample_end = (state_q == ST_SAMPLE)  && (cnt_q == CNT_W'(SAMPLE_CYC - 1));
    assign bit_end    = (state_q == ST_CONVERT) && (cnt_q == CNT_W'(SETTLE));
    assign conv_end   = bit_end && (bit_q == '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start && (|ch_mask)) state_d = ST_SELECT;
            ST_SELECT:  state_d = pick_found ? ST_SAMPLE : ST_IDLE;
            ST_SAMPLE:  if (sample_end) state_d = ST_CONVERT;
            ST_CONVERT: if (conv_end) state_d = last_pass ? ST_DONE : ST_SAMPLE;
            ST_DONE:    state_d = ((|pending_q) || cont) ? ST_SELECT : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // Comparator synchronizer, scheduling state and successive-approximation datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            mask_q      <= '0;
            pending_q   <= '0;
            ch_q        <= '0;
            last_q      <= CW'(N_CH - 1);
            cnt_q       <= '0;
            bit_q       <= '0;
            code_q      <= '0;
            result_q    <= '0;
            result_ch_q <= '0;
`ifdef SAR_AVG_EN
            avg_q       <= '0;
            acc_q       <= '0;
`endif
        end else begin
            sync1_q <= cmp_in;
            sync2_q <= sync1_q;
            if (abort) begin
                pending_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start && (|ch_mask)) begin
                            mask_q    <= ch_mask;
                            pending_q <= ch_mask;
                        end
                    end
                    ST_SELECT: begin
                        pending_q <= pending_q & ~pick_oh;
                        ch_q      <= pick_idx;
                        last_q    <= pick_idx;
                        cnt_q     <= '0;
`ifdef SAR_AVG_EN
                        avg_q     <= '0;
                        acc_q     <= '0;
`endif
                    end
                    ST_SAMPLE: begin
                        if (sample_end) begin
                            cnt_q  <= '0;
                            bit_q  <= BW'(RES - 1);
                            code_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_CONVERT: begin
                        if (bit_end) begin
                            cnt_q <= '0;
                            if (bit_q == '0) begin
`ifdef SAR_AVG_EN
                                if (last_pass) begin
                                    result_q    <= acc_n[RES+1:2];
                                    result_ch_q <= ch_q;
                                end else begin
                                    acc_q <= acc_n;
                                    avg_q <= avg_q + 2'd1;
                                end
`else
                                result_q    <= new_code;
                                result_ch_q <= ch_q;
`endif
                            end else begin
                                code_q <= new_code;
                                bit_q  <= bit_q - BW'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        if ((pending_q == '0) && cont) pending_q <= mask_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs decoded from state; ch_sel shows the fresh pick during SELECT.
    always_comb begin
        sample       = (state_q == ST_SAMPLE);
        busy         = (state_q != ST_IDLE);
        result_valid = (state_q == ST_DONE);
        dac_code     = (state_q == ST_CONVERT) ? (code_q | trial_oh) : '0;
        ch_sel       = (state_q == ST_SELECT) ? pick_idx : ch_q;
        result       = result_q;
        result_ch    = result_ch_q;
    end

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Directed bench for sar_scan_ctrl with an ideal comparator (vin >= dac_code).
module tb_sar_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, cont, abort, cmp_in;
    logic [3:0] ch_mask;
    logic       sample, busy, result_valid;
    logic [1:0] ch_sel, result_ch;
    logic [7:0] dac_code, result;
    logic [7:0] vin [4];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign cmp_in = (vin[ch_sel] >= dac_code);

    sar_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
        .ch_mask(ch_mask), .cmp_in(cmp_in), .sample(sample), .ch_sel(ch_sel),
        .dac_code(dac_code), .busy(busy), .result_valid(result_valid),
        .result(result), .result_ch(result_ch)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    endtask

    task automatic pulse_start(input logic [3:0] m);
        ch_mask = m; start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0 || sample !== 1'b0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl got busy=%b sample=%b rv=%b want 0 0 0", busy, sample, result_valid); end
        checks++; if (dac_code !== 8'h00 || ch_sel !== 2'd0) begin
            errors++; $display("FAIL reset_dac got dac=%h ch_sel=%0d want 00 0", dac_code, ch_sel); end
        checks++; if (result !== 8'h00 || result_ch !== 2'd0) begin
            errors++; $display("FAIL reset_result got %h ch%0d want 00 ch0", result, result_ch); end
        tick(); rst = 1'b0; tick();
    endtask

    task automatic test_single();
        int first = -1, nrv = 0;
        logic [7:0] r = '0; logic [1:0] c = '0; logic b38 = 1'b1;
        vin[2] = 8'hA5;
        pulse_start(4'b0100);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise got %b want 1", busy); end
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (result_valid) begin
                nrv++;
                if (first < 0) begin first = i; r = result; c = result_ch; end
            end
            if (i == 38) b38 = busy;
        end
        checks++; if (first != 37) begin errors++; $display("FAIL single_latency got %0d want 37", first); end
        checks++; if (r !== 8'hA5) begin errors++; $display("FAIL single_result got %h want a5", r); end
        checks++; if (c !== 2'd2) begin errors++; $display("FAIL single_ch got %0d want 2", c); end
        checks++; if (nrv != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", nrv); end
        checks++; if (b38 !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %b want 0", b38); end
    endtask

    task automatic test_multi();
        int cyc [3]; logic [7:0] res [3]; logic [1:0] chn [3];
        int exp_cyc [3] = '{37, 75, 113};
        logic [7:0] exp_res [3] = '{8'h00, 8'hFF, 8'h3C};
        logic [1:0] exp_ch [3] = '{2'd0, 2'd1, 2'd3};
        int k = 0; logic b114 = 1'b1;
        do_reset();
        vin[0] = 8'h00; vin[1] = 8'hFF; vin[3] = 8'h3C;
        pulse_start(4'b1011);
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (result_valid) begin
                if (k < 3) begin cyc[k] = i; res[k] = result; chn[k] = result_ch; end
                k++;
            end
            if (i == 114) b114 = busy;
        end
        checks++; if (k != 3) begin errors++; $display("FAIL multi_count got %0d want 3", k); end
        for (int j = 0; j < 3 && j < k; j++) begin
            checks++; if (cyc[j] != exp_cyc[j] || res[j] !== exp_res[j] || chn[j] !== exp_ch[j]) begin
                errors++; $display("FAIL multi_%0d got cyc=%0d res=%h ch=%0d want cyc=%0d res=%h ch=%0d",
                                   j, cyc[j], res[j], chn[j], exp_cyc[j], exp_res[j], exp_ch[j]); end
        end
        checks++; if (b114 !== 1'b0) begin errors++; $display("FAIL multi_busy_fall got %b want 0", b114); end
    endtask

    task automatic test_cont();
        int cyc [4]; logic [1:0] chn [4];
        int exp_cyc [4] = '{37, 75, 113, 151};
        logic [1:0] exp_ch [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
        int k = 0; logic b152 = 1'b1;
        do_reset();
        vin[0] = 8'h11; vin[1] = 8'h22;
        cont = 1'b1;
        pulse_start(4'b0011);
        for (int i = 1; i <= 220; i++) begin
            tick();
            if (result_valid) begin
                if (k < 4) begin cyc[k] = i; chn[k] = result_ch; end
                k++;
                if (k == 3) cont = 1'b0;
            end
            if (i == 152) b152 = busy;
        end
        cont = 1'b0;
        checks++; if (k != 4) begin errors++; $display("FAIL cont_count got %0d want 4", k); end
        for (int j = 0; j < 4 && j < k; j++) begin
            checks++; if (cyc[j] != exp_cyc[j] || chn[j] !== exp_ch[j]) begin
                errors++; $display("FAIL cont_%0d got cyc=%0d ch=%0d want cyc=%0d ch=%0d",
                                   j, cyc[j], chn[j], exp_cyc[j], exp_ch[j]); end
        end
        checks++; if (b152 !== 1'b0) begin errors++; $display("FAIL cont_busy_fall got %b want 0", b152); end
        checks++; if (result !== 8'h22) begin errors++; $display("FAIL cont_last_result got %h want 22", result); end
    endtask

    task automatic test_busy_start();
        int first = -1, nrv = 0;
        logic [7:0] r = '0; logic [1:0] c = '0;
        vin[2] = 8'h5A;
        pulse_start(4'b0100);
        for (int i = 1; i <= 90; i++) begin
            tick();
            if (result_valid) begin
                nrv++;
                if (first < 0) begin first = i; r = result; c = result_ch; end
            end
            if (i == 10) begin start = 1'b1; ch_mask = 4'hF; end
            else start = 1'b0;
        end
        checks++; if (nrv != 1 || first != 37) begin
            errors++; $display("FAIL busy_start_pulses got n=%0d first=%0d want n=1 first=37", nrv, first); end
        checks++; if (r !== 8'h5A || c !== 2'd2) begin
            errors++; $display("FAIL busy_start_result got %h ch%0d want 5a ch2", r, c); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b want 0", busy); end
    endtask

    task automatic test_abort();
        int nrv = 0; logic [7:0] d18 = '0; logic b19 = 1'b1; logic [7:0] d19 = 8'hFF;
        vin[3] = 8'h77;
        pulse_start(4'b1000);
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (result_valid) nrv++;
            if (i == 18) begin d18 = dac_code; abort = 1'b1; end
            if (i == 19) begin b19 = busy; d19 = dac_code; abort = 1'b0; end
        end
        checks++; if (d18 !== 8'h70) begin errors++; $display("FAIL abort_trial_code got %h want 70", d18); end
        checks++; if (b19 !== 1'b0 || d19 !== 8'h00) begin
            errors++; $display("FAIL abort_idle got busy=%b dac=%h want 0 00", b19, d19); end
        checks++; if (nrv != 0) begin errors++; $display("FAIL abort_no_result got %0d want 0", nrv); end
        checks++; if (result !== 8'h5A || result_ch !== 2'd2) begin
            errors++; $display("FAIL abort_keep_result got %h ch%0d want 5a ch2", result, result_ch); end
    endtask

    task automatic test_abort_done();
        int nrv = 0; logic rv37 = 1'b0; logic b38 = 1'b1;
        vin[0] = 8'h11; vin[1] = 8'h22;
        cont = 1'b1;
        pulse_start(4'b0011);
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (result_valid) nrv++;
            if (i == 37) begin rv37 = result_valid; abort = 1'b1; end
            if (i == 38) begin b38 = busy; abort = 1'b0; end
        end
        cont = 1'b0;
        checks++; if (rv37 !== 1'b1) begin errors++; $display("FAIL abort_done_pulse got %b want 1", rv37); end
        checks++; if (b38 !== 1'b0 || nrv != 1) begin
            errors++; $display("FAIL abort_done_stop got busy=%b n=%0d want 0 1", b38, nrv); end
    endtask

    task automatic test_async_rst();
        int nb = 0;
        vin[2] = 8'hA5;
        pulse_start(4'b0100);
        for (int i = 1; i <= 20; i++) tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || sample !== 1'b0 || dac_code !== 8'h00 || ch_sel !== 2'd0) begin
            errors++; $display("FAIL async_rst_ctrl got busy=%b sample=%b dac=%h ch_sel=%0d want 0 0 00 0",
                               busy, sample, dac_code, ch_sel); end
        checks++; if (result !== 8'h00 || result_ch !== 2'd0) begin
            errors++; $display("FAIL async_rst_result got %h ch%0d want 00 ch0", result, result_ch); end
        tick(); rst = 1'b0; tick();
        pulse_start(4'b0000);
        for (int i = 0; i < 6; i++) begin
            if (busy) nb++;
            tick();
        end
        checks++; if (nb != 0) begin errors++; $display("FAIL zero_mask_busy got %0d busy cycles want 0", nb); end
    endtask

`ifdef SAR_AVG_EN
    task automatic test_avg();
        int first = -1, nsamp = 0, nrv = 0;
        logic prev = 1'b0; logic [7:0] r = '0; logic [1:0] c = '0;
        do_reset();
        vin[1] = 8'h40;
        pulse_start(4'b0010);
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (sample && !prev) begin
                nsamp++;
                vin[1] = (nsamp % 2 == 1) ? 8'h40 : 8'h43;
            end
            prev = sample;
            if (result_valid) begin
                nrv++;
                if (first < 0) begin first = i; r = result; c = result_ch; end
            end
        end
        checks++; if (first != 145 || nrv != 1) begin
            errors++; $display("FAIL avg_timing got first=%0d n=%0d want 145 1", first, nrv); end
        checks++; if (r !== 8'h41 || c !== 2'd1) begin
            errors++; $display("FAIL avg_result got %h ch%0d want 41 ch1", r, c); end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; ch_mask = 4'h0;
        for (int i = 0; i < 4; i++) vin[i] = 8'h00;
        test_reset();
`ifdef SAR_AVG_EN
        test_avg();
`else
        test_single();
        test_multi();
        test_cont();
        test_busy_start();
        test_abort();
        test_abort_done();
        test_async_rst();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_scan_ctrl.md
# sar_scan_ctrl

Successive-approximation conversion controller and channel scheduler for the mixed-signal test chip's on-die analog front end. It sequences the shared track/hold, capacitive DAC and comparator through binary-search conversions. It also time-shares that single converter round-robin among up to N_CH analog input channels. It sits between the digital top level (mode pins, result readout) and the analog macro's control pins.

## Interface
- N_CH, 4: number of analog input channels (2..8).
- RES, 8: conversion resolution in bits.
- SAMPLE_CYC, 4: track/hold acquisition cycles per conversion (>=1).
- SETTLE, 3: DAC/comparator settle cycles per bit, including the 2-flop comparator synchronizer (>=2).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a scan; ignored while busy.
- cont  in  1  1 = repeat scans until abort; 0 = single scan.
- abort  in  1  terminates any activity; return to IDLE next cycle.
- ch_mask  in  N_CH  enabled channels; latched at scan start.
- cmp_in  in  1  raw asynchronous comparator output; 1 = Vin >= Vdac.
- sample  out  1  track/hold switch closed.
- ch_sel  out  clog2(N_CH)  analog mux select.
- dac_code  out  RES  DAC trial code.
- busy  out  1  scan in progress.
- result_valid  out  1  one-cycle pulse, result and result_ch valid.
- result  out  RES  last conversion result; holds until next pulse.
- result_ch  out  clog2(N_CH)  channel of result.

## Operation
- States: IDLE, SELECT, SAMPLE, CONVERT, DONE.
- IDLE: busy=0, sample=0, dac_code=0. On start with nonzero ch_mask: latch mask into pending set, go SELECT. Start with ch_mask==0 is ignored.
- SELECT (1 cycle): pick the next pending channel round-robin, starting after the last converted channel (after reset: channel 0 first). Drive ch_sel and clear that channel's pending bit.
- SAMPLE (SAMPLE_CYC cycles): sample=1.
- CONVERT: bits processed MSB to LSB. For each bit: dac_code = kept bits | trial bit. Wait SETTLE+1 cycles. On the final cycle, the synchronized comparator value decides whether the trial bit is kept (1) or cleared (0).
- DONE (1 cycle): result_valid=1, result/result_ch updated.
  - If the pending set is nonempty, go SELECT.
  - Else, if cont=1, reload the pending set from the latched mask and go SELECT.
  - Else, go IDLE.
- ch_sel holds its value through SAMPLE/CONVERT/DONE.
- abort has priority over every transition. Next state is IDLE with no result_valid, and the pending set is cleared. result/result_ch keep their prior values.
- start is ignored while busy. cont is sampled only in DONE.

## Timing
- Reset values: sample=0, ch_sel=0, dac_code=0, busy=0, result_valid=0, result=0, result_ch=0. Comparator synchronizer flops=0. Round-robin pointer set so channel 0 is picked first.
- busy is high from the cycle after start is accepted through DONE of the last conversion.
- Latency: result_valid is asserted L = 1 + SAMPLE_CYC + RES*(SETTLE+1) cycles after the start edge. Defaults give L=37.
- Back-to-back conversions within a scan are spaced L+1 cycles apart (38 at defaults).
- An abort during DONE suppresses the state advance. result_valid still pulses in that cycle.

## Configuration
- SAR_AVG_EN defined:
  - Each selected channel is converted 4 times consecutively (SELECT once, then SAMPLE/CONVERT repeated) into an RES+2-bit accumulator.
  - result = accumulator[RES+1:2].
  - result_valid pulses only after the 4th conversion.
- SAR_AVG_EN undefined: single conversion per channel; no accumulator hardware.

## Structure
- Package sar_pkg contains:
  - the state enum;
  - default parameter constants;
  - the function computing L.
- Sub-module sar_rr_pick: combinational round-robin picker over the pending mask and last-channel pointer, returning the next channel index and a found flag.

## Test plan
- Comparator model cmp=(vin>=dac_code). ch_mask=0100, vin[2]=0xA5, start → single result_valid 37 cycles later, result=0xA5, result_ch=2, then IDLE and busy=0.
- ch_mask=1011, vin={0x00,0xFF,-,0x3C} for ch0, ch1, ch3 → results in order ch0=0x00, ch1=0xFF, ch3=0x3C, spaced 38 cycles apart.
- cont=1, ch_mask=0011 → ch0, ch1, ch0, ch1…. Deassert cont mid-scan → stops after ch1, busy falls.
- abort asserted in CONVERT bit 4 → IDLE next cycle, no result_valid, result keeps previous value. Start while busy is ignored.
- Async rst asserted mid-conversion → all outputs return to reset values immediately. start with ch_mask=0 → busy stays 0.
- SAR_AVG_EN, vin[1] toggling 0x40/0x43 between conversions → result=0x41 after 4 conversions.
